morra_match_driver: RTL and testbench

//  Stimulus-side counterpart of the rock-paper-scissors (morra) referee.

---
 rtl/morra_match_driver_if.sv | 12 +
 rtl/morra_match_driver.sv | 232 +++++++++++++++++++++++
 tb/tb_morra_match_driver.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/morra_match_driver_if.sv
// Referee-side bus of the morra match driver: match-open strobe, move pair out,
// round/match verdicts back.
interface morra_match_driver_if;
  logic       inizio;
  logic [1:0] primo;
  logic [1:0] secondo;
  logic [1:0] manche;
  logic [1:0] partita;

  modport master (output inizio, output primo, output secondo, input manche, input partita);
  modport slave  (input inizio, input primo, input secondo, output manche, output partita);
endinterface

// File: rtl/morra_match_driver.sv
// Morra match driver: opens a match on the referee, plays LFSR-generated moves and keeps score.
// Optional shadow referee enabled by defining MORRA_SCOREBOARD_EN (adds o_mismatch).
module morra_match_driver #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          MAX_INVALID = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [3:0]           i_cfg_rounds,
  morra_match_driver_if.master ref_bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_result,
  output logic [4:0]           o_rounds,
  output logic [4:0]           o_score1,
  output logic [4:0]           o_score2,
  output logic                 o_err
`ifdef MORRA_SCOREBOARD_EN
  ,
  output logic                 o_mismatch
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_PLAY, S_DONE} state_t;

  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int          CW       = $clog2(MAX_INVALID + 2);

  state_t r_state, w_state_nxt;
  logic [15:0] r_lfsr, w_lfsr_nxt;
  logic [1:0]  r_last_win, w_lw_nxt, r_last_move, w_lm_nxt;
  logic [4:0]  r_rounds, w_rounds_nxt, r_score1, w_score1_nxt, r_score2, w_score2_nxt;
  logic [4:0]  r_limit;
  logic [CW-1:0] r_inv, w_inv_nxt;
  logic [1:0]  r_result, w_result_nxt;
  logic        r_err, w_err_nxt;
  logic        r_inizio, r_busy, r_done;
  logic [1:0]  r_primo, r_secondo, w_p1, w_p2;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    if (v == 5'd31) return v;
    else return v + 5'd1;
  endfunction

  function automatic logic [1:0] map_move(input logic [1:0] f);
    case (f)
      2'd0:    return 2'b01;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] rot_move(input logic [1:0] m);
    case (m)
      2'b01:   return 2'b10;
      2'b10:   return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and next scoring values; verdict of a PLAY cycle is taken at its closing edge
  always_comb begin
    w_state_nxt  = r_state;
    w_lw_nxt     = r_last_win;
    w_lm_nxt     = r_last_move;
    w_rounds_nxt = r_rounds;
    w_score1_nxt = r_score1;
    w_score2_nxt = r_score2;
    w_inv_nxt    = r_inv;
    w_result_nxt = r_result;
    w_err_nxt    = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt  = S_INIT;
          w_lw_nxt     = 2'b00;
          w_lm_nxt     = 2'b00;
          w_rounds_nxt = 5'd0;
          w_score1_nxt = 5'd0;
          w_score2_nxt = 5'd0;
          w_inv_nxt    = '0;
          w_result_nxt = 2'b00;
          w_err_nxt    = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_INIT: w_state_nxt = S_PLAY;
      S_PLAY: begin
        if (ref_bus.manche == 2'b00) begin
          w_inv_nxt = r_inv + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          w_inv_nxt    = '0;
          w_rounds_nxt = sat_inc(r_rounds);
          w_lw_nxt     = ref_bus.manche;
          case (ref_bus.manche)
            2'b01: begin
              w_score1_nxt = sat_inc(r_score1);
              w_lm_nxt     = r_primo;
            end
            2'b10: begin
              w_score2_nxt = sat_inc(r_score2);
              w_lm_nxt     = r_secondo;
            end
            default: w_lm_nxt = 2'b00;
          endcase
        end
        // A decided match wins over any abort condition in the same cycle
        if (ref_bus.partita != 2'b00) begin
          w_result_nxt = ref_bus.partita;
          w_state_nxt  = S_DONE;
        end else if ((w_inv_nxt > CW'(MAX_INVALID)) || (w_rounds_nxt == r_limit)) begin
          w_err_nxt    = 1'b1;
          w_result_nxt = 2'b00;
          w_state_nxt  = S_DONE;
        end else begin
          w_state_nxt = S_PLAY;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next move pair from the stepped LFSR, with the last winner barred from repeating its move
  always_comb begin
    w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    w_p1 = map_move(w_lfsr_nxt[1:0]);
    w_p2 = map_move(w_lfsr_nxt[3:2]);
    if ((w_lw_nxt == 2'b01) && (w_p1 == w_lm_nxt)) w_p1 = rot_move(w_p1);
    else w_p1 = w_p1;
    if ((w_lw_nxt == 2'b10) && (w_p2 == w_lm_nxt)) w_p2 = rot_move(w_p2);
    else w_p2 = w_p2;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr      <= SEED_EFF;
      r_last_win  <= 2'b00;
      r_last_move <= 2'b00;
      r_rounds    <= 5'd0;
      r_score1    <= 5'd0;
      r_score2    <= 5'd0;
      r_limit     <= 5'd0;
      r_inv       <= '0;
      r_result    <= 2'b00;
      r_err       <= 1'b0;
      r_inizio    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_primo     <= 2'b00;
      r_secondo   <= 2'b00;
    end else begin
      r_last_win  <= w_lw_nxt;
      r_last_move <= w_lm_nxt;
      r_rounds    <= w_rounds_nxt;
      r_score1    <= w_score1_nxt;
      r_score2    <= w_score2_nxt;
      r_inv       <= w_inv_nxt;
      r_result    <= w_result_nxt;
      r_err       <= w_err_nxt;
      r_inizio    <= (w_state_nxt == S_INIT);
      r_busy      <= (w_state_nxt == S_INIT) || (w_state_nxt == S_PLAY);
      r_done      <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_INIT) begin
        r_primo   <= i_cfg_rounds[3:2];
        r_secondo <= i_cfg_rounds[1:0];
        r_limit   <= 5'd5 + {1'b0, i_cfg_rounds};
      end else if (w_state_nxt == S_PLAY) begin
        r_lfsr    <= w_lfsr_nxt;
        r_primo   <= w_p1;
        r_secondo <= w_p2;
      end else begin
        r_primo   <= 2'b00;
        r_secondo <= 2'b00;
      end
    end
  end

`ifdef MORRA_SCOREBOARD_EN
  logic r_mismatch, w_mm_nxt;

  function automatic logic [1:0] beats(input logic [1:0] a, input logic [1:0] b);
    if (a == b) return 2'b11;
    else if (((a == 2'b10) && (b == 2'b01)) || ((a == 2'b01) && (b == 2'b11)) ||
             ((a == 2'b11) && (b == 2'b10))) return 2'b01;
    else return 2'b10;
  endfunction

  // Shadow referee: flags any verdict that disagrees with the move pair actually driven
  always_comb begin
    w_mm_nxt = r_mismatch;
    if ((r_state == S_IDLE) && i_start) begin
      w_mm_nxt = 1'b0;
    end else if (r_state == S_PLAY) begin
      if (ref_bus.manche != beats(r_primo, r_secondo)) w_mm_nxt = 1'b1;
      else w_mm_nxt = r_mismatch;
    end else begin
      w_mm_nxt = r_mismatch;
    end
  end

  // Sticky mismatch flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mismatch <= 1'b0;
    else        r_mismatch <= w_mm_nxt;
  end

  assign o_mismatch = r_mismatch;
`endif

  assign ref_bus.inizio  = r_inizio;
  assign ref_bus.primo   = r_primo;
  assign ref_bus.secondo = r_secondo;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_rounds = r_rounds;
  assign o_score1 = r_score1;
  assign o_score2 = r_score2;
  assign o_err    = r_err;

endmodule

// File: tb/tb_morra_match_driver.sv
// Directed bench for morra_match_driver: reset, P1 win streak, invalid-reply abort,
// round-limit abort and (with MORRA_SCOREBOARD_EN) the shadow-referee mismatch flag.
module tb_morra_match_driver;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] cfg_rounds;
  logic       busy, done, err;
  logic [1:0] result;
  logic [4:0] rounds, score1, score2;
`ifdef MORRA_SCOREBOARD_EN
  logic       mismatch;
`endif

  logic       ref_mode;
  logic       ref_flip;
  logic [1:0] tb_manche, tb_partita, w_manche;
  int         n_checks = 0;
  int         n_fail   = 0;

  morra_match_driver_if bus ();

  morra_match_driver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_cfg_rounds (cfg_rounds),
    .ref_bus      (bus.master),
    .o_busy       (busy),
    .o_done       (done),
    .o_result     (result),
    .o_rounds     (rounds),
    .o_score1     (score1),
    .o_score2     (score2),
    .o_err        (err)
`ifdef MORRA_SCOREBOARD_EN
    ,
    .o_mismatch   (mismatch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] ref_verdict(input logic [1:0] p1, input logic [1:0] p2);
    if (p1 == p2) return 2'b11;
    if ((p1 == 2'b10 && p2 == 2'b01) || (p1 == 2'b01 && p2 == 2'b11) || (p1 == 2'b11 && p2 == 2'b10))
      return 2'b01;
    return 2'b10;
  endfunction

  // Bench referee: either scripted verdicts or a real referee with an optional flipped verdict
  always_comb begin
    w_manche = tb_manche;
    if (ref_mode) begin
      w_manche = ref_verdict(bus.primo, bus.secondo);
      if (ref_flip && w_manche == 2'b01) w_manche = 2'b10;
      else if (ref_flip && w_manche == 2'b10) w_manche = 2'b01;
    end
  end
  assign bus.manche  = w_manche;
  assign bus.partita = tb_partita;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] prev_p1, cur_p1, tv;
    bit flipped;
    rst_n = 1'b0; start = 1'b1; cfg_rounds = 4'b0110;
    ref_mode = 1'b0; ref_flip = 1'b0; tb_manche = 2'b01; tb_partita = 2'b00;
    prev_p1 = 2'b00; flipped = 1'b0;

    // Reset held with start high
    tick(); tick();
    chk("rst_inizio", int'(bus.inizio), 0);
    chk("rst_moves", int'({bus.primo, bus.secondo}), 0);
    chk("rst_busy_done_err", int'({busy, done, err}), 0);
    chk("rst_result_rounds", int'({result, rounds}), 0);
    chk("rst_scores", int'({score1, score2}), 0);
    @(negedge clk); rst_n = 1'b1;

    // INIT drives the round code
    tick();
    chk("init_inizio", int'(bus.inizio), 1);
    chk("init_primo", int'(bus.primo), 1);
    chk("init_secondo", int'(bus.secondo), 2);
    chk("init_busy", int'(busy), 1);
    start = 1'b0;

    // P1 wins four straight
    tick();
    chk("play_inizio_low", int'(bus.inizio), 0);
    for (int i = 0; i < 4; i++) begin
      cur_p1 = bus.primo;
      chk("p1_legal", int'(cur_p1 != 2'b00), 1);
      if (i > 0) chk("p1_norepeat", int'(cur_p1 != prev_p1), 1);
      prev_p1 = cur_p1;
      tb_partita = (i == 3) ? 2'b01 : 2'b00;
      tick();
    end
    tb_partita = 2'b00;
    chk("win_done", int'(done), 1);
    chk("win_busy", int'(busy), 0);
    chk("win_score1", int'(score1), 4);
    chk("win_score2", int'(score2), 0);
    chk("win_rounds", int'(rounds), 4);
    chk("win_result", int'(result), 1);
    chk("win_moves_idle", int'({bus.primo, bus.secondo}), 0);
    tick();
    chk("win_done_pulse", int'(done), 0);
    chk("win_result_hold", int'(result), 1);

    // Three invalid replies abort the match; start held high must not reopen it
    tb_manche = 2'b00; start = 1'b1;
    tick();
    chk("inv_init_clear", int'({result, score1}), 0);
    tick();
    chk("inv_start_ignored", int'(bus.inizio), 0);
    tick(); tick();
    chk("inv_still_busy", int'({busy, done, err}), 3'b100);
    tick();
    start = 1'b0;
    chk("inv_done", int'(done), 1);
    chk("inv_err", int'(err), 1);
    chk("inv_result", int'(result), 0);
    chk("inv_counters", int'({rounds, score1, score2}), 0);
    tick();

    // Endless draws with limit code 0 abort after five rounds
    cfg_rounds = 4'b0000; tb_manche = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    chk("lim_init_err_clr", int'(err), 0);
    chk("lim_init_inizio", int'(bus.inizio), 1);
    tick();
    tick(); tick(); tick(); tick();
    chk("lim_rounds4", int'(rounds), 4);
    chk("lim_busy4", int'({busy, done}), 2'b10);
    tick();
    chk("lim_rounds5", int'(rounds), 5);
    chk("lim_err", int'(err), 1);
    chk("lim_done", int'(done), 1);
    chk("lim_result", int'(result), 0);
    chk("lim_scores", int'({score1, score2}), 0);
    tick();

`ifdef MORRA_SCOREBOARD_EN
    // Real referee; one decisive verdict is flipped
    cfg_rounds = 4'b1111; ref_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("sb_init_clear", int'(mismatch), 0);
    tick(); tick();
    chk("sb_clean", int'(mismatch), 0);
    for (int i = 0; i < 12 && !flipped; i++) begin
      tv = ref_verdict(bus.primo, bus.secondo);
      if (tv != 2'b11) begin
        ref_flip = 1'b1;
        flipped = 1'b1;
      end
      tick();
      ref_flip = 1'b0;
    end
    chk("sb_flip_found", int'(flipped), 1);
    chk("sb_mismatch_set", int'(mismatch), 1);
    tb_partita = 2'b11;
    tick();
    tb_partita = 2'b00;
    chk("sb_done", int'(done), 1);
    chk("sb_mismatch_sticky", int'(mismatch), 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sb_mismatch_clr", int'(mismatch), 0);
    ref_mode = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
